// File: rtl/core_debug_pkg.sv
// Shared definitions for the core debug register-dump logic.
//   - dump_state_t: top-level dump sequencer states
//   - NUM_REGS / BYTES_PER_WORD / REG_ADDR_W: dump geometry
package core_debug_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StDone,
    StAbort
  } dump_state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Serializes one register word into bytes, least-significant byte first.
// Ports:
//   clock, reset     - system clock, asynchronous active-high reset
//   load_i, word_i   - load a new word (starts a fresh byte sequence)
//   byte_o, valid_o  - current byte and its valid flag (both registered)
//   ready_i          - downstream accepts byte_o when valid_o is high
//   word_done_o      - high on the handshake of the final byte of the word
module word_byte_serializer
  import core_debug_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [7:0]        byte_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              word_done_o
);

  localparam int unsigned CountW = $clog2(BYTES_PER_WORD);
  localparam logic [CountW-1:0] LastCount = CountW'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] shift_d, shift_q;
  logic [CountW-1:0] count_d, count_q;
  logic              valid_d, valid_q;

  always_comb begin
    shift_d     = shift_q;
    count_d     = count_q;
    valid_d     = valid_q;
    word_done_o = 1'b0;
    if (load_i) begin
      shift_d = word_i;
      count_d = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      shift_d = {8'h00, shift_q[WORD_W-1:8]};
      count_d = count_q + 1'b1;
      if (count_q == LastCount) begin
        word_done_o = 1'b1;
        valid_d     = 1'b0;
        count_d     = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign byte_o  = shift_q[7:0];
  assign valid_o = valid_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug-side register file dumper. While the core is halted, walks register
// addresses 0..NUM_REGS-1 through the rs1 read port and streams each word out
// as bytes (LSB first) over a valid/ready interface.
// Ports:
//   clock, reset              - system clock, asynchronous active-high reset
//   dump_request, core_halted - start pulse (honoured only when idle and halted)
//   read_address, read_select - register address and rs1 mux select (= busy)
//   read_data                 - combinational register file read data
//   byte_out, byte_valid      - output byte stream
//   byte_ready                - downstream accept
//   busy, done, aborted       - status; done/aborted are one-cycle pulses
module regfile_dump_reader
  import core_debug_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dump_request,
  input  logic                  core_halted,
  output logic [REG_ADDR_W-1:0] read_address,
  output logic                  read_select,
  input  logic [WORD_W-1:0]     read_data,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam logic [REG_ADDR_W-1:0] LastIndex = REG_ADDR_W'(NUM_REGS - 1);

  dump_state_t           state_d, state_q;
  logic [REG_ADDR_W-1:0] index_d, index_q;
  logic [REG_ADDR_W-1:0] read_address_d, read_address_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  aborted_d, aborted_q;
  logic                  ser_load;
  logic                  word_done;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    ser_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_request && core_halted) begin
          state_d = StLoad;
          index_d = '0;
        end
      end
      StLoad: begin
        // Halt lost since the last word: abandon without capturing.
        if (!core_halted) begin
          state_d = StAbort;
        end else begin
          ser_load = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (word_done) begin
          if (index_q == LastIndex) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StDone, StAbort: state_d = StIdle;
      default:         state_d = StIdle;
    endcase

    // Outputs are registered, so derive them from the next state.
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    aborted_d = (state_d == StAbort);
    if (state_d == StLoad) begin
      read_address_d = index_d;
    end else if (state_d == StIdle) begin
      read_address_d = '0;
    end else begin
      read_address_d = read_address_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      index_q        <= '0;
      read_address_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      read_address_q <= read_address_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  word_byte_serializer u_serializer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (ser_load),
    .word_i     (read_data),
    .byte_o     (byte_out),
    .valid_o    (byte_valid),
    .ready_i    (byte_ready),
    .word_done_o(word_done)
  );

  assign read_address = read_address_q;
  assign read_select  = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule
